// File: rtl/sd_sector_loader.sv
// Streams SECTORS consecutive SD sectors into RAM as little-endian packed words,
// pulsing update at each slot boundary so the slot table can record its start.
module sd_sector_loader #(
  parameter int unsigned SECTORS      = 64,
  parameter int unsigned SLOT_SECTORS = 16,
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned RAM_AW       = 27,
  parameter logic [31:0] SD_BASE      = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              sd_ready,
  input  logic [7:0]        sd_dout,
  input  logic              sd_byte_available,
  output logic [31:0]       sd_address,
  output logic              sd_rd,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [RAM_AW-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              update,
  output logic [7:0]        slot_idx,
  output logic [RAM_AW-1:0] start_a,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam int unsigned BPW       = WORD_W / 8;
  localparam int unsigned SEC_W     = $clog2(SECTORS + 1);
  localparam logic [8:0]  LANE_MASK = 9'(BPW - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_REC, S_NEXT, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [SEC_W-1:0]    r_sector, w_sector_inc, w_sector_nxt;
  logic [8:0]          r_byte_cnt;
  logic                r_bav_q, r_rd_hold;
  logic [WORD_W-1:0]   r_word_buf, w_word_nxt, r_wr_data;
  logic                r_wr_valid, w_wr_valid_nxt;
  logic [RAM_AW-1:0]   r_wr_addr, w_wr_addr_nxt, r_start_a;
  logic                r_update, r_overflow;
  logic [7:0]          r_slot_idx;
  logic [31:0]         r_sd_address, w_sector32;
  logic                w_bav_rise, w_load_go, w_capture, w_last_lane, w_word_done;
  logic                w_accept, w_word_take, w_enter_start, w_slot_start;
  logic                w_sd_rd, w_busy, w_done;

  // A level held on sd_byte_available is one byte: only its first cycle counts.
  assign w_bav_rise    = sd_byte_available & ~r_bav_q;
  assign w_load_go     = load & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_capture     = (r_state == S_REC) & w_bav_rise;
  assign w_last_lane   = (r_byte_cnt & LANE_MASK) == LANE_MASK;
  assign w_word_done   = w_capture & w_last_lane;
  assign w_accept      = r_wr_valid & wr_ready;
  assign w_word_take   = w_word_done & (~r_wr_valid | w_accept);
  assign w_sector_inc  = r_sector + SEC_W'(1);
  assign w_sector_nxt  = w_load_go ? '0 : ((r_state == S_NEXT) ? w_sector_inc : r_sector);
  assign w_sector32    = 32'(w_sector_nxt);
  assign w_wr_addr_nxt = w_load_go ? '0 : (w_accept ? r_wr_addr + RAM_AW'(1) : r_wr_addr);
  assign w_enter_start = (w_state_nxt == S_START) & (r_state != S_START);
  assign w_slot_start  = w_enter_start & ((w_sector32 % SLOT_SECTORS) == 32'd0);

  always_comb begin
    w_wr_valid_nxt = r_wr_valid;
    if (w_load_go)        w_wr_valid_nxt = 1'b0;
    else if (w_word_take) w_wr_valid_nxt = 1'b1;
    else if (w_accept)    w_wr_valid_nxt = 1'b0;
  end

  always_comb begin
    w_word_nxt = r_word_buf;
    for (int unsigned k = 0; k < BPW; k++) begin
      if ((r_byte_cnt & LANE_MASK) == 9'(k)) w_word_nxt[8*k +: 8] = sd_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (load) w_state_nxt = S_START;
      S_START:        if (sd_ready) w_state_nxt = S_REC;
      S_REC:          if (w_capture && r_byte_cnt == 9'd511) w_state_nxt = S_NEXT;
      S_NEXT:         w_state_nxt = (w_sector_inc == SEC_W'(SECTORS)) ? S_DONE : S_START;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sd_rd = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_START: begin w_sd_rd = sd_ready;  w_busy = 1'b1; end
      S_REC:   begin w_sd_rd = r_rd_hold; w_busy = 1'b1; end
      S_NEXT:  w_busy = 1'b1;
      S_DONE:  w_done = ~r_wr_valid;
      default: ;
    endcase
  end

  // Handshake: a word is held in wr_data/wr_addr while wr_valid=1 and is
  // consumed on the first clock edge that sees wr_valid && wr_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sector     <= '0;
      r_byte_cnt   <= '0;
      r_bav_q      <= 1'b0;
      r_rd_hold    <= 1'b0;
      r_word_buf   <= '0;
      r_wr_valid   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_update     <= 1'b0;
      r_slot_idx   <= '0;
      r_start_a    <= '0;
      r_sd_address <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_bav_q    <= sd_byte_available;
      r_sector   <= w_sector_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_update   <= w_slot_start;
      if (w_load_go)      r_byte_cnt <= '0;
      else if (w_capture) r_byte_cnt <= r_byte_cnt + 9'd1;
      if (w_capture)   r_word_buf <= w_word_nxt;
      if (w_word_take) r_wr_data  <= w_word_nxt;
      if (r_state == S_START && sd_ready)    r_rd_hold <= 1'b1;
      else if (r_state == S_REC && !sd_ready) r_rd_hold <= 1'b0;
      if (w_load_go)
        r_overflow <= 1'b0;
      else if ((w_word_done && r_wr_valid && !w_accept) ||
               (w_bav_rise && (r_state == S_START || r_state == S_NEXT)))
        r_overflow <= 1'b1;
      // start_a names the next word to be written, counting one still pending.
      if (w_slot_start) begin
        r_slot_idx <= 8'(w_sector32 / SLOT_SECTORS);
        r_start_a  <= w_wr_addr_nxt + RAM_AW'(w_wr_valid_nxt);
      end
      if (w_enter_start) r_sd_address <= SD_BASE + (w_sector32 << 9);
    end
  end

  assign sd_address = r_sd_address;
  assign sd_rd      = w_sd_rd;
  assign wr_valid   = r_wr_valid;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign update     = r_update;
  assign slot_idx   = r_slot_idx;
  assign start_a    = r_start_a;
  assign busy       = w_busy;
  assign done       = w_done;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_sd_sector_loader.sv
// Directed bench for sd_sector_loader: two-sector load, backpressure overflow,
// load-while-busy, mid-load reset and a byte arriving in START.
module tb_sd_sector_loader;
  localparam int unsigned AW = 27;
  localparam int unsigned DW = 16;
  localparam int unsigned W  = AW + DW;

  logic          clk = 1'b0;
  logic          reset, load, sd_ready, sd_byte_available, wr_ready;
  logic [7:0]    sd_dout;
  logic [31:0]   sd_address;
  logic          sd_rd, wr_valid, update, busy, done, overflow;
  logic [AW-1:0] wr_addr, start_a;
  logic [DW-1:0] wr_data;
  logic [7:0]    slot_idx;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_writes = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_word;

  sd_sector_loader #(
    .SECTORS(2), .SLOT_SECTORS(1), .WORD_W(DW), .RAM_AW(AW), .SD_BASE(32'h200)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .sd_ready(sd_ready), .sd_dout(sd_dout),
    .sd_byte_available(sd_byte_available), .sd_address(sd_address), .sd_rd(sd_rd),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .update(update), .slot_idx(slot_idx), .start_a(start_a), .busy(busy),
    .done(done), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // scoreboard: every accepted RAM write must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && wr_valid && wr_ready) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $error("FAIL write_unexpected observed=%0h expected=none", {wr_addr, wr_data});
      end else begin
        exp_word = exp_q.pop_front();
        assert ({wr_addr, wr_data} === exp_word) else begin
          n_errors++;
          $error("FAIL write observed=%0h expected=%0h", {wr_addr, wr_data}, exp_word);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    sd_dout = b;
    sd_byte_available = 1'b1;
    repeat (hold) step();
    sd_byte_available = 1'b0;
    step();
  endtask

  task automatic push_exp(input int addr, input logic [15:0] data);
    exp_q.push_back({AW'(addr), data});
  endtask

  task automatic sd_handshake(input int hi_cycles);
    sd_ready = 1'b1;
    repeat (hi_cycles) step();
    sd_ready = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_sd_rd"}, 32'(sd_rd), 0);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 0);
    chk({tag, "_update"}, 32'(update), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_sd_address"}, sd_address, 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_slot_idx"}, 32'(slot_idx), 0);
    chk({tag, "_start_a"}, 32'(start_a), 0);
  endtask

  function automatic logic [7:0] f1(input int i);
    return 8'(i + 1);
  endfunction

  function automatic logic [7:0] f2(input int i);
    return 8'(i * 3 + 5);
  endfunction

  initial begin
    reset = 1'b1; load = 1'b0; sd_ready = 1'b0; sd_byte_available = 1'b0;
    sd_dout = 8'h00; wr_ready = 1'b1;
    step(); step();
    check_all_zero("reset");
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // first load: slot 0 update, SD address, sd_rd held until sd_ready drops
    for (int w = 0; w < 512; w++) push_exp(w, {f1(2*w+1), f1(2*w)});
    load = 1'b1;
    step();
    load = 1'b0;
    chk("l1_update", 32'(update), 1);
    chk("l1_slot_idx", 32'(slot_idx), 0);
    chk("l1_start_a", 32'(start_a), 0);
    chk("l1_sd_address", sd_address, 32'h200);
    chk("l1_busy", 32'(busy), 1);
    chk("l1_sd_rd_start_idle", 32'(sd_rd), 0);
    sd_ready = 1'b1;
    step();
    chk("l1_update_pulse_end", 32'(update), 0);
    chk("l1_sd_rd_c1", 32'(sd_rd), 1);
    step();
    chk("l1_sd_rd_c2", 32'(sd_rd), 1);
    step();
    chk("l1_sd_rd_c3", 32'(sd_rd), 1);
    sd_ready = 1'b0;
    step();
    chk("l1_sd_rd_dropped", 32'(sd_rd), 0);

    // four bytes held four cycles each pack into two words
    for (int i = 0; i < 4; i++) send_byte(f1(i), 4);
    chk("four_bytes_writes", 32'(n_writes), 2);
    chk("four_bytes_wr_addr", 32'(wr_addr), 2);
    chk("four_bytes_sd_rd", 32'(sd_rd), 0);

    for (int i = 4; i < 512; i++) send_byte(f1(i), 1);
    for (int t = 0; t < 20 && !update; t++) step();
    chk("l1_update2_seen", 32'(update), 1);
    chk("l1_slot_idx2", 32'(slot_idx), 1);
    chk("l1_start_a2", 32'(start_a), 256);
    chk("l1_sd_address2", sd_address, 32'h400);
    sd_handshake(1);
    for (int i = 512; i < 1024; i++) send_byte(f1(i), 1);
    for (int t = 0; t < 20 && !done; t++) step();
    chk("l1_done_seen", 32'(done), 1);
    chk("l1_writes", 32'(n_writes), 512);
    chk("l1_exp_empty", 32'(exp_q.size()), 0);
    chk("l1_wr_addr_end", 32'(wr_addr), 512);
    chk("l1_overflow", 32'(overflow), 0);
    step(); step(); step();
    chk("l1_done_hold", 32'(done), 1);
    chk("l1_busy_done", 32'(busy), 0);

    // backpressure: second completed word is dropped, first kept
    load = 1'b1;
    step();
    load = 1'b0;
    chk("l2_update", 32'(update), 1);
    chk("l2_start_a", 32'(start_a), 0);
    chk("l2_done_cleared", 32'(done), 0);
    chk("l2_wr_addr_cleared", 32'(wr_addr), 0);
    sd_handshake(1);
    wr_ready = 1'b0;
    send_byte(8'hA1, 2);
    send_byte(8'hB2, 2);
    chk("ovf_pending_valid", 32'(wr_valid), 1);
    chk("ovf_no_flag_yet", 32'(overflow), 0);
    send_byte(8'hC3, 2);
    send_byte(8'hD4, 2);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_pending_data", 32'(wr_data), 32'hB2A1);
    chk("ovf_pending_addr", 32'(wr_addr), 0);
    chk("ovf_still_valid", 32'(wr_valid), 1);
    push_exp(0, 16'hB2A1);
    wr_ready = 1'b1;
    step();
    chk("ovf_drained", 32'(wr_valid), 0);
    step(); step();
    chk("ovf_second_absent", 32'(wr_addr), 1);

    // load during REC is ignored; byte stream continues in place
    load = 1'b1;
    step(); step();
    load = 1'b0;
    chk("busy_load_no_update", 32'(update), 0);
    chk("busy_load_busy", 32'(busy), 1);
    chk("busy_load_sd_address", sd_address, 32'h200);
    chk("busy_load_overflow_kept", 32'(overflow), 1);
    push_exp(1, 16'h2211);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    chk("busy_load_wr_addr", 32'(wr_addr), 2);
    chk("busy_load_exp_empty", 32'(exp_q.size()), 0);

    // reset after 300 bytes with the last word still pending
    reset = 1'b1;
    step();
    reset = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    sd_handshake(1);
    for (int w = 0; w < 149; w++) push_exp(w, {f2(2*w+1), f2(2*w)});
    for (int i = 0; i < 298; i++) send_byte(f2(i), 1);
    wr_ready = 1'b0;
    send_byte(f2(298), 1);
    send_byte(f2(299), 1);
    chk("rst_pending_valid", 32'(wr_valid), 1);
    chk("rst_pending_data", 32'(wr_data), 32'({f2(299), f2(298)}));
    reset = 1'b1;
    step();
    check_all_zero("midrst");
    reset = 1'b0;
    wr_ready = 1'b1;
    step(); step();
    chk("midrst_no_write", 32'(wr_valid), 0);
    chk("midrst_exp_empty", 32'(exp_q.size()), 0);

    // restart; a byte arriving in START is dropped and flags overflow
    load = 1'b1;
    step();
    load = 1'b0;
    chk("l4_update", 32'(update), 1);
    chk("l4_sd_address", sd_address, 32'h200);
    chk("l4_wr_addr", 32'(wr_addr), 0);
    chk("l4_overflow_clear", 32'(overflow), 0);
    send_byte(8'hEE, 2);
    chk("start_byte_overflow", 32'(overflow), 1);
    chk("start_byte_busy", 32'(busy), 1);
    sd_handshake(1);
    push_exp(0, 16'h3C5A);
    send_byte(8'h5A, 1);
    send_byte(8'h3C, 1);
    chk("l4_wr_addr_end", 32'(wr_addr), 1);
    chk("l4_exp_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
